// File: rtl/rt_ibex_window_ctrl_if.sv
// Handshake bundle between the core trap logic, the window controller and the window file.
// Latency: none, wires only.
// Backpressure: level requests held until the one-cycle ack; no other flow control.
//
// Ports (controller side = slave modport):
//   entry_req_i / exit_req_i    : trap-entry and mret requests from the core (level)
//   window_full_i               : last hardware window in use, from the window file
//   entry_ack_o / exit_ack_o    : one-cycle acknowledges
//   hw_window_o                 : ack qualifier, 1 = hardware window switched
//   err_o                       : protocol-error pulse, coincident with its ack
//   increment_ptr_o / decrement_ptr_o / save_csr_o : window-file strobes
//   restore_csr_o               : CSR file loads mcause/mepc from the window file
//   busy_o, depth_o, stat_overflow_o : status
interface rt_ibex_window_ctrl_if #(
    parameter int NumRegisterWindows = 4,
    parameter int SwDepthWidth       = 4
);
    localparam int DepthW = $clog2(NumRegisterWindows) + SwDepthWidth;

    logic              entry_req_i;
    logic              exit_req_i;
    logic              window_full_i;
    logic              entry_ack_o;
    logic              exit_ack_o;
    logic              hw_window_o;
    logic              err_o;
    logic              increment_ptr_o;
    logic              decrement_ptr_o;
    logic              save_csr_o;
    logic              restore_csr_o;
    logic              busy_o;
    logic [DepthW-1:0] depth_o;
    logic [15:0]       stat_overflow_o;

    // Controller side
    modport slave (
        input  entry_req_i,
        input  exit_req_i,
        input  window_full_i,
        output entry_ack_o,
        output exit_ack_o,
        output hw_window_o,
        output err_o,
        output increment_ptr_o,
        output decrement_ptr_o,
        output save_csr_o,
        output restore_csr_o,
        output busy_o,
        output depth_o,
        output stat_overflow_o
    );

    // Core / window-file side
    modport master (
        output entry_req_i,
        output exit_req_i,
        output window_full_i,
        input  entry_ack_o,
        input  exit_ack_o,
        input  hw_window_o,
        input  err_o,
        input  increment_ptr_o,
        input  decrement_ptr_o,
        input  save_csr_o,
        input  restore_csr_o,
        input  busy_o,
        input  depth_o,
        input  stat_overflow_o
    );
endinterface

// File: rtl/rt_ibex_window_ctrl.sv
// Interrupt-nesting controller: maps trap entry / mret onto register-window strobes, spills to SW when full.
// Latency: HW entry/exit ack in N+2 (strobe in N+1); software-path and error ack in N+1.
// Backpressure: requests are level signals held until ack; sampled only in IDLE, entry wins over exit.
//
// Ports: clk_i (core clock), rst_i (synchronous, active-high), win (rt_ibex_window_ctrl_if.slave,
// see the interface file for the per-signal summary).
// Optional feature: define RT_IBEX_WINDOW_STATS_EN to build the 16-bit saturating overflow-entry
// counter on stat_overflow_o; without it the output is tied to zero.
// NumRegisterWindows must be >= 2 and equal to the window file's setting.
module rt_ibex_window_ctrl #(
    parameter int NumRegisterWindows = 4,
    parameter int SwDepthWidth       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rt_ibex_window_ctrl_if.slave  win
);

    localparam int HwW    = $clog2(NumRegisterWindows);
    localparam int DepthW = HwW + SwDepthWidth;

    localparam logic [HwW-1:0]          HwMax  = HwW'(NumRegisterWindows - 1);
    localparam logic [SwDepthWidth-1:0] SwFull = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENT_SAVE = 3'd1,
        ENT_INC  = 3'd2,
        EXT_DEC  = 3'd3,
        EXT_RST  = 3'd4,
        SW_ACK   = 3'd5,
        ERR_ACK  = 3'd6
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    // Remembers whether the transaction in flight is an entry; SW_ACK and
    // ERR_ACK are shared between entry and exit and need it to pick the ack.
    logic                    op_entry_q;
    logic                    op_entry_d;
    logic [HwW-1:0]          hw_depth_q;
    logic [SwDepthWidth-1:0] sw_depth_q;

    logic hw_full;
    logic sw_active;

    // window_full_i is authoritative, but the local count also blocks a
    // hardware entry that would step past the last window.
    assign hw_full   = win.window_full_i || (hw_depth_q == HwMax);
    assign sw_active = (sw_depth_q != '0);

    // ------------------------------------------------------------------
    // State register and nesting counters
    // ------------------------------------------------------------------
    // Depth counters move on the edge that ends the ack cycle so depth_o
    // shows the new value in the first cycle after the ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_entry_q <= 1'b0;
            hw_depth_q <= '0;
            sw_depth_q <= '0;
        end else begin
            state_q    <= state_d;
            op_entry_q <= op_entry_d;
            case (state_q)
                ENT_INC: hw_depth_q <= hw_depth_q + 1'b1;
                EXT_RST: hw_depth_q <= hw_depth_q - 1'b1;
                SW_ACK: begin
                    if (op_entry_q) begin
                        sw_depth_q <= sw_depth_q + 1'b1;
                    end else begin
                        sw_depth_q <= sw_depth_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        op_entry_d = op_entry_q;
        case (state_q)
            IDLE: begin
                if (win.entry_req_i) begin
                    op_entry_d = 1'b1;
                    if (sw_depth_q == SwFull) begin
                        state_d = ERR_ACK;
                    end else if (hw_full || sw_active) begin
                        // Once spilling has started every deeper level stays
                        // in software so unwinding remains strictly LIFO.
                        state_d = SW_ACK;
                    end else begin
                        state_d = ENT_SAVE;
                    end
                end else if (win.exit_req_i) begin
                    op_entry_d = 1'b0;
                    if (sw_active) begin
                        state_d = SW_ACK;
                    end else if (hw_depth_q != '0) begin
                        state_d = EXT_DEC;
                    end else begin
                        state_d = ERR_ACK;
                    end
                end
            end
            ENT_SAVE: state_d = ENT_INC;
            ENT_INC:  state_d = IDLE;
            // Pointer moves first so the aux read in EXT_RST already shows
            // the enclosing level's stacked mcause/mepc.
            EXT_DEC:  state_d = EXT_RST;
            EXT_RST:  state_d = IDLE;
            SW_ACK:   state_d = IDLE;
            ERR_ACK:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode; one state per strobe keeps them exclusive
    // ------------------------------------------------------------------
    logic shared_ack;

    assign shared_ack = (state_q == SW_ACK) || (state_q == ERR_ACK);

    assign win.save_csr_o      = (state_q == ENT_SAVE);
    assign win.increment_ptr_o = (state_q == ENT_INC);
    assign win.decrement_ptr_o = (state_q == EXT_DEC);
    assign win.restore_csr_o   = (state_q == EXT_RST);

    assign win.entry_ack_o = (state_q == ENT_INC) || (shared_ack && op_entry_q);
    assign win.exit_ack_o  = (state_q == EXT_RST) || (shared_ack && !op_entry_q);
    assign win.hw_window_o = (state_q == ENT_INC) || (state_q == EXT_RST);
    assign win.err_o       = (state_q == ERR_ACK);
    assign win.busy_o      = (state_q != IDLE);

    assign win.depth_o = DepthW'(hw_depth_q) + DepthW'(sw_depth_q);

    // ------------------------------------------------------------------
    // Overflow statistics
    // ------------------------------------------------------------------
`ifdef RT_IBEX_WINDOW_STATS_EN
    logic [15:0] stat_q;

    // Counts overflow-path entry acks only; error acks are not overflows.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else if ((state_q == SW_ACK) && op_entry_q && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign win.stat_overflow_o = stat_q;
`else
    assign win.stat_overflow_o = '0;
`endif

endmodule

// File: tb/tb_rt_ibex_window_ctrl.sv
module tb_rt_ibex_window_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rt_ibex_window_ctrl_if #(.NumRegisterWindows(4), .SwDepthWidth(4)) bus ();

    rt_ibex_window_ctrl #(.NumRegisterWindows(4), .SwDepthWidth(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .win   (bus)
    );

    // Output pattern bit order: {save, inc, dec, restore, entry_ack, exit_ack, hw_window, err}
    localparam logic [7:0] P_SAVE    = 8'b1000_0000;
    localparam logic [7:0] P_ENT_HW  = 8'b0100_1010;
    localparam logic [7:0] P_DEC     = 8'b0010_0000;
    localparam logic [7:0] P_EXT_HW  = 8'b0001_0110;
    localparam logic [7:0] P_ENT_SW  = 8'b0000_1000;
    localparam logic [7:0] P_EXT_SW  = 8'b0000_0100;
    localparam logic [7:0] P_ERR_EXT = 8'b0000_0101;
    localparam logic [7:0] P_ERR_ENT = 8'b0000_1001;

    typedef struct packed {
        logic [7:0] pat;
        logic [5:0] depth;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

`ifdef RT_IBEX_WINDOW_STATS_EN
    localparam int STAT_ON = 1;
`else
    localparam int STAT_ON = 0;
`endif

    function automatic logic [7:0] dut_pat();
        return {bus.save_csr_o, bus.increment_ptr_o, bus.decrement_ptr_o, bus.restore_csr_o,
                bus.entry_ack_o, bus.exit_ack_o, bus.hw_window_o, bus.err_o};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    // Monitor: every cycle with any strobe/ack must match the next expected item.
    always @(negedge clk) begin
        logic [7:0] pat;
        exp_t       e;
        pat = dut_pat();
        if (pat != 8'h00) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: got pattern %b depth %0d, expected nothing", pat, bus.depth_o);
            end else begin
                e = exp_q.pop_front();
                if (pat === e.pat && bus.depth_o === e.depth) passes++;
                else $display("FAIL output_cycle: got pattern %b depth %0d, expected pattern %b depth %0d",
                              pat, bus.depth_o, e.pat, e.depth);
            end
        end
    end

    // Raise the requested lines, drop each one at its ack, bounded wait.
    task automatic run_req(input bit ent, input bit ext);
        bit ent_p;
        bit ext_p;
        int n;
        ent_p = ent;
        ext_p = ext;
        n     = 0;
        @(negedge clk);
        bus.entry_req_i = ent;
        bus.exit_req_i  = ext;
        while ((ent_p || ext_p) && n < 40) begin
            @(negedge clk);
            n++;
            if (ent_p && bus.entry_ack_o) begin ent_p = 1'b0; bus.entry_req_i = 1'b0; end
            if (ext_p && bus.exit_ack_o)  begin ext_p = 1'b0; bus.exit_req_i  = 1'b0; end
        end
        if (ent_p || ext_p) begin
            checks++;
            $display("FAIL ack_timeout: got no ack within %0d cycles, expected ack", n);
            bus.entry_req_i = 1'b0;
            bus.exit_req_i  = 1'b0;
        end
        @(negedge clk);
    endtask

    function automatic void push(input logic [7:0] p, input int d);
        exp_t e;
        e.pat   = p;
        e.depth = 6'(d);
        exp_q.push_back(e);
    endfunction

    task automatic ent_hw(input int d);
        push(P_SAVE, d); push(P_ENT_HW, d);
        run_req(1'b1, 1'b0);
        chk("depth_after_hw_entry", int'(bus.depth_o), d + 1);
    endtask

    task automatic ent_sw(input int d);
        push(P_ENT_SW, d);
        run_req(1'b1, 1'b0);
        chk("depth_after_sw_entry", int'(bus.depth_o), d + 1);
    endtask

    task automatic ext_hw(input int d);
        push(P_DEC, d); push(P_EXT_HW, d);
        run_req(1'b0, 1'b1);
        chk("depth_after_hw_exit", int'(bus.depth_o), d - 1);
    endtask

    task automatic ext_sw(input int d);
        push(P_EXT_SW, d);
        run_req(1'b0, 1'b1);
        chk("depth_after_sw_exit", int'(bus.depth_o), d - 1);
    endtask

    initial begin
        bus.entry_req_i   = 1'b0;
        bus.exit_req_i    = 1'b0;
        bus.window_full_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(dut_pat()), 0);
        chk("reset_busy", int'(bus.busy_o), 0);
        chk("reset_depth", int'(bus.depth_o), 0);
        chk("reset_stat", int'(bus.stat_overflow_o), 0);
        rst = 1'b0;

        // Three hardware entries, then overflow entry with the file full
        ent_hw(0);
        ent_hw(1);
        ent_hw(2);
        bus.window_full_i = 1'b1;
        ent_sw(3);
        chk("stat_after_overflow", int'(bus.stat_overflow_o), STAT_ON * 1);

        // LIFO unwind: software level first, then three hardware levels
        ext_sw(4);
        ext_hw(3);
        bus.window_full_i = 1'b0;
        ext_hw(2);
        ext_hw(1);

        // Exit at depth 0 is a protocol error
        push(P_ERR_EXT, 0);
        run_req(1'b0, 1'b1);
        chk("depth_after_err_exit", int'(bus.depth_o), 0);

        // Simultaneous requests at depth 1: entry first, exit stays pending
        ent_hw(0);
        push(P_SAVE, 1); push(P_ENT_HW, 1);
        push(P_DEC, 2);  push(P_EXT_HW, 2);
        run_req(1'b1, 1'b1);
        chk("depth_after_simultaneous", int'(bus.depth_o), 1);
        ext_hw(1);

        // Fill the software counter to all-ones, then one more entry errors
        ent_hw(0);
        ent_hw(1);
        ent_hw(2);
        bus.window_full_i = 1'b1;
        for (int i = 0; i < 15; i++) ent_sw(3 + i);
        push(P_ERR_ENT, 18);
        run_req(1'b1, 1'b0);
        chk("depth_after_err_entry", int'(bus.depth_o), 18);
        chk("stat_after_sw_fill", int'(bus.stat_overflow_o), STAT_ON * 16);
        for (int i = 0; i < 15; i++) ext_sw(18 - i);
        ext_hw(3);
        bus.window_full_i = 1'b0;
        ext_hw(2);
        ext_hw(1);

        // Reset in ENT_SAVE abandons the entry; no increment may follow
        push(P_SAVE, 0);
        @(negedge clk);
        bus.entry_req_i = 1'b1;
        @(negedge clk);
        chk("ent_save_busy", int'(bus.busy_o), 1);
        rst             = 1'b1;
        bus.entry_req_i = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", int'(dut_pat()), 0);
        chk("midreset_busy", int'(bus.busy_o), 0);
        chk("midreset_depth", int'(bus.depth_o), 0);
        chk("midreset_stat", int'(bus.stat_overflow_o), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
